des_perm_pipe: RTL and testbench

- Parametrised, pipelined DES bit-permutation engine; successor to the combinational initial-permutation block.
- Applies either the initial permutation (IP) or the final permutation (FP = IP⁻¹) to LANES independent 64-bit blocks per beat, selected per beat.
- Sits between the block-input/output buffering and the round datapath in des_top, with full valid/ready flow control and configurable register depth.

---
 rtl/des_perm_pipe.sv | 106 ++++++++++
 tb/tb_des_perm_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP bit-permutation engine: LANES 64-bit blocks per beat,
// STAGES register stages with a combinational valid/ready accept chain.
module des_perm_pipe #(
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [64*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [64*LANES-1:0]   out_data,
    output logic [32*LANES-1:0]   out_lo,
    output logic [32*LANES-1:0]   out_ro,
    output logic                  busy
);

    localparam int W = 64 * LANES;

    // DES bit n (1-based) sits at vector index 64-n. IP source bits follow two
    // interleaved descending columns: even bits in rows 0-3, odd in rows 4-7.
    function automatic logic [63:0] des_perm(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int          row;
        int          col;
        int          src;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            row = i / 8;
            col = i % 8;
            src = (row < 4) ? (58 + 2 * row - 8 * col) : (57 + 2 * (row - 4) - 8 * col);
            if (inv) y[64 - src] = x[63 - i];
            else     y[63 - i]   = x[64 - src];
        end
        return y;
    endfunction

    logic [W-1:0]      perm_d;
    logic [W-1:0]      data_q [STAGES];
    logic [STAGES-1:0] mode_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] acc;

    always_comb begin
        perm_d = '0;
        for (int k = 0; k < LANES; k++) begin
            perm_d[64*k +: 64] = des_perm(in_data[64*k +: 64], in_mode);
        end
    end

    // A stage accepts when empty or when the stage below it is moving.
    always_comb begin
        acc = '0;
        acc[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            acc[s] = !v_q[s] || acc[s+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            mode_q <= '0;
            // NOTE: data registers are reset too, since out_data must read 0 in reset.
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            if (acc[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= perm_d;
                    mode_q[0] <= in_mode;
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (acc[s]) begin
                    v_q[s] <= v_q[s-1];
                    if (v_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                        mode_q[s] <= mode_q[s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready  = acc[0];
        out_valid = v_q[STAGES-1];
        out_mode  = mode_q[STAGES-1];
        out_data  = data_q[STAGES-1];
        busy      = |v_q;
        out_lo    = '0;
        out_ro    = '0;
        for (int k = 0; k < LANES; k++) begin
            out_lo[32*k +: 32] = data_q[STAGES-1][64*k + 32 +: 32];
            out_ro[32*k +: 32] = data_q[STAGES-1][64*k +: 32];
        end
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: a LANES=1/STAGES=2 instance for reference vectors
// and reset, a LANES=2/STAGES=3 instance for flow control and random traffic.
module tb_des_perm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode, a_busy;
    logic [63:0] a_in_data, a_out_data;
    logic [31:0] a_out_lo, a_out_ro;

    logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic [63:0]  b_out_lo, b_out_ro;

    des_perm_pipe #(.LANES(1), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data),
        .out_lo(a_out_lo), .out_ro(a_out_ro), .busy(a_busy));

    des_perm_pipe #(.LANES(2), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data),
        .out_lo(b_out_lo), .out_ro(b_out_ro), .busy(b_busy));

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct { logic mode; logic [127:0] data; } beat_t;
    beat_t sbq [$];

    typedef struct { logic mode; logic [63:0] din; logic [63:0] dout; } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) begin
            y[63 - i] = inv ? x[64 - FP_TAB[i]] : x[64 - IP_TAB[i]];
        end
        return y;
    endfunction

    function automatic logic [127:0] exp_b(input logic m, input logic [127:0] d);
        return {ref_perm(d[127:64], m), ref_perm(d[63:0], m)};
    endfunction

    task automatic b_cycle(input logic iv, input logic m, input logic [127:0] d, input logic ordy,
                           output logic ir, output logic ov, output logic [127:0] od,
                           output logic om, output logic [63:0] olo, output logic [63:0] oro);
        @(negedge clk);
        b_in_valid  = iv;
        b_in_mode   = m;
        b_in_data   = d;
        b_out_ready = ordy;
        #1;
        ir  = b_in_ready;
        ov  = b_out_valid;
        od  = b_out_data;
        om  = b_out_mode;
        olo = b_out_lo;
        oro = b_out_ro;
        @(posedge clk);
    endtask

    task automatic b_pop(input logic [127:0] od, input logic om, input logic [63:0] olo, input logic [63:0] oro);
        beat_t        e;
        logic [127:0] ed;
        if (sbq.size() == 0) begin
            check("b_spurious_out", 1'b1, 1'b0);
        end else begin
            e  = sbq.pop_front();
            ed = exp_b(e.mode, e.data);
            check("b_data", od, ed);
            check("b_mode", om, e.mode);
            check("b_lo", olo, {ed[127:96], ed[63:32]});
            check("b_ro", oro, {ed[95:64], ed[31:0]});
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic         ir, ov, om;
    logic [127:0] od, ref_d;
    logic [63:0]  olo, oro;

    initial begin
        vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA};
        vecs[1] = '{1'b1, 64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b0, 64'h8000000000000000, 64'h0000000001000000};
        vecs[3] = '{1'b1, 64'h0000000001000000, 64'h8000000000000000};
        vecs[4] = '{1'b0, 64'h0000000000000001, 64'h0000008000000000};
        vecs[5] = '{1'b1, 64'h0000000000000001, 64'h0200000000000000};
        vecs[6] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[7] = '{1'b1, 64'h0000000000000000, 64'h0000000000000000};

        rst_n = 1'b0;
        a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 0;
        #1;
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_out_data", a_out_data, 64'h0);
        check("rst_b_in_ready", b_in_ready, 1'b1);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_b_out_data", b_out_data, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference vectors through the 2-stage single-lane pipe
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_mode = vecs[v].mode; a_in_data = vecs[v].din; a_out_ready = 1;
            #1 check($sformatf("a_in_ready[%0d]", v), a_in_ready, 1'b1);
            @(negedge clk);
            a_in_valid = 0;
            check($sformatf("a_early_valid[%0d]", v), a_out_valid, 1'b0);
            @(negedge clk);
            check($sformatf("a_valid[%0d]", v), a_out_valid, 1'b1);
            check($sformatf("a_data[%0d]", v), a_out_data, vecs[v].dout);
            check($sformatf("a_lo[%0d]", v), a_out_lo, vecs[v].dout[63:32]);
            check($sformatf("a_ro[%0d]", v), a_out_ro, vecs[v].dout[31:0]);
            check($sformatf("a_mode[%0d]", v), a_out_mode, vecs[v].mode);
        end

        // Reset mid-stream with two FP beats held in the pipe
        @(negedge clk);
        a_out_ready = 0; a_in_valid = 1; a_in_mode = 1; a_in_data = 64'h0123456789ABCDEF;
        @(negedge clk);
        a_in_data = 64'hFEDCBA9876543210;
        @(negedge clk);
        a_in_valid = 0;
        check("a_full_busy", a_busy, 1'b1);
        check("a_full_valid", a_out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("a_rst_out_valid", a_out_valid, 1'b0);
        check("a_rst_busy", a_busy, 1'b0);
        check("a_rst_out_data", a_out_data, 64'h0);
        check("a_rst_lo_ro", {a_out_lo, a_out_ro}, 64'h0);
        check("a_rst_mode", a_out_mode, 1'b0);
        check("a_rst_in_ready", a_in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        a_in_valid = 1; a_in_mode = 0; a_in_data = 64'h0123456789ABCDEF; a_out_ready = 1;
        #1 check("a_post_rst_in_ready", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 0;
        @(negedge clk);
        check("a_post_rst_valid", a_out_valid, 1'b1);
        check("a_post_rst_data", a_out_data, 64'hCC00CCFFF0AAF0AA);
        @(negedge clk);
        check("a_post_rst_drained", a_out_valid, 1'b0);

        // Back-to-back alternating modes, out_ready held high
        begin
            int outs = 0, first_out = -1, last_out = -1;
            for (int k = 0; k < 8 + 3 + 2; k++) begin
                logic [127:0] d;
                d = rnd128();
                b_cycle(k < 8, k[0], d, 1'b1, ir, ov, od, om, olo, oro);
                if (k < 8) begin
                    check($sformatf("b2b_in_ready[%0d]", k), ir, 1'b1);
                    if (ir) sbq.push_back('{k[0], d});
                end
                if (ov) begin
                    b_pop(od, om, olo, oro);
                    if (first_out < 0) first_out = k;
                    last_out = k;
                    outs++;
                end
            end
            check("b2b_count", outs, 8);
            check("b2b_latency", first_out, 3);
            check("b2b_contiguous", last_out - first_out, 7);
        end

        // Backpressure: 5 beats offered against a stalled 3-stage pipe
        begin
            logic [127:0] bd [5];
            int           idx = 0, outs = 0;
            logic         stable_ok = 1, have_ref = 0, last_ir = 1;
            for (int i = 0; i < 5; i++) bd[i] = rnd128();
            for (int c = 0; c < 8; c++) begin
                b_cycle(idx < 5, idx[0], (idx < 5) ? bd[idx % 5] : '0, 1'b0, ir, ov, od, om, olo, oro);
                last_ir = ir;
                if (idx < 5 && ir) begin
                    sbq.push_back('{idx[0], bd[idx]});
                    idx++;
                end
                if (ov) begin
                    if (!have_ref) begin ref_d = od; have_ref = 1; end
                    else if (od !== ref_d) stable_ok = 0;
                end
            end
            check("bp_accepted", idx, 3);
            check("bp_in_ready_low", last_ir, 1'b0);
            check("bp_busy", b_busy, 1'b1);
            check("bp_saw_valid", have_ref, 1'b1);
            check("bp_stable", stable_ok, 1'b1);
            for (int c = 0; c < 30 && outs < 5; c++) begin
                b_cycle(idx < 5, idx[0], (idx < 5) ? bd[idx % 5] : '0, 1'b1, ir, ov, od, om, olo, oro);
                if (idx < 5 && ir) begin
                    sbq.push_back('{idx[0], bd[idx]});
                    idx++;
                end
                if (ov) begin b_pop(od, om, olo, oro); outs++; end
            end
            check("bp_all_out", outs, 5);
            check("bp_sb_empty", sbq.size(), 0);
        end

        // Randomised traffic against the table-based scoreboard
        begin
            int           sent = 0, outs = 0, cyc = 0;
            logic         have = 0, hm = 0, ordy, prev_stall = 0, prev_m = 0, stall_ok = 1;
            logic [127:0] hd = '0, prev_d = '0;
            while (outs < 10000 && cyc < 60000) begin
                if (!have && sent < 10000) begin
                    have = ($urandom_range(0, 4) != 0);
                    hm   = $urandom_range(0, 1) != 0;
                    hd   = rnd128();
                end
                ordy = ($urandom_range(0, 4) != 0);
                b_cycle(have, hm, hd, ordy, ir, ov, od, om, olo, oro);
                if (prev_stall && (!ov || od !== prev_d || om !== prev_m)) stall_ok = 0;
                if (have && ir) begin
                    sbq.push_back('{hm, hd});
                    sent++;
                    have = 0;
                end
                if (ov && ordy) begin b_pop(od, om, olo, oro); outs++; end
                prev_stall = ov && !ordy;
                prev_d = od;
                prev_m = om;
                cyc++;
            end
            check("rand_outs", outs, 10000);
            check("rand_sb_empty", sbq.size(), 0);
            check("rand_stall_stable", stall_ok, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
